// File: rtl/ring_counter_pkg.sv
// Shared types and helpers for the multi-mode ring counter.
// Lengths are carried as 6 bits and patterns as 32 bits so the helpers work
// for every legal WIDTH (2..32); callers truncate to their own width.
package ring_counter_pkg;

  typedef enum logic [1:0] {
    RC_ONEHOT  = 2'b00,
    RC_JOHNSON = 2'b01,
    RC_ONECOLD = 2'b10
  } rc_mode_t;

  // Raw mode code to sequence type; the unused code 11 behaves as one-hot.
  function automatic rc_mode_t rc_norm_mode(input logic [1:0] m);
    rc_mode_t r;
    case (m)
      2'b01:   r = RC_JOHNSON;
      2'b10:   r = RC_ONECOLD;
      default: r = RC_ONEHOT;
    endcase
    return r;
  endfunction

  // Requested active length forced into 2..width.
  function automatic logic [5:0] rc_clamp_len(input logic [5:0] len, input logic [5:0] width);
    logic [5:0] r;
    if (len < 6'd2)
      r = 6'd2;
    else if (len > width)
      r = width;
    else
      r = len;
    return r;
  endfunction

  // Ones in bits [len-1:0]; 33-bit intermediate so len=32 does not overflow.
  function automatic logic [31:0] rc_len_mask(input logic [5:0] len);
    logic [32:0] m;
    m = (33'd1 << len) - 33'd1;
    return m[31:0];
  endfunction

  // Number of distinct states before the sequence repeats.
  function automatic logic [6:0] rc_period(input rc_mode_t m, input logic [5:0] len);
    return (m == RC_JOHNSON) ? {len, 1'b0} : {1'b0, len};
  endfunction

  // The pattern a sequence shows at a given position (pos < period).
  function automatic logic [31:0] rc_pattern_at(input rc_mode_t m, input logic [5:0] len,
                                                input logic [6:0] pos);
    logic [31:0] mask;
    logic [31:0] p;
    mask = rc_len_mask(len);
    case (m)
      RC_JOHNSON: begin
        if (pos <= {1'b0, len})
          p = rc_len_mask(pos[5:0]);
        else
          p = mask & ~rc_len_mask(pos[5:0] - len);
      end
      RC_ONECOLD: p = ~(32'd1 << pos[4:0]) & mask;
      default:    p = (32'd1 << pos[4:0]) & mask;
    endcase
    return p;
  endfunction

  // Pattern shown at position 0 after a mode/length change or rejected load.
  function automatic logic [31:0] rc_init_pattern(input rc_mode_t m, input logic [5:0] len);
    return rc_pattern_at(m, len, 7'd0);
  endfunction

endpackage

// File: rtl/ring_counter_multi_decode.sv
// Combinational pattern checker: tells whether a pattern belongs to the
// sequence selected by mode and active length, and where in the cycle it sits.
module ring_pattern_decode
  import ring_counter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int POSW  = $clog2(2 * WIDTH)
) (
  input  logic [WIDTH-1:0] i_pattern,
  input  rc_mode_t         i_mode,
  input  logic [5:0]       i_len,
  output logic             o_legal,
  output logic [POSW-1:0]  o_index
);

  logic [31:0] w_patExt;
  logic [6:0]  w_period;

  assign w_patExt = 32'(i_pattern);
  assign w_period = rc_period(i_mode, i_len);

  // Compare against every position of the cycle and report the first match.
  always_comb begin
    o_legal = 1'b0;
    o_index = '0;
    for (int i = 0; i < 2 * WIDTH; i++) begin
      if ((7'(i) < w_period) && !o_legal &&
          (rc_pattern_at(i_mode, i_len, 7'(i)) == w_patExt)) begin
        o_legal = 1'b1;
        o_index = POSW'(i);
      end
    end
  end

endmodule

// File: rtl/ring_counter_multi.sv
// Multi-mode ring counter: one-hot, one-cold or Johnson sequence over a
// programmable active length, with direction, checked load, position and
// wrap/illegal pulses. All outputs come straight from registers.
module ring_counter_multi
  import ring_counter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LENW  = $clog2(WIDTH) + 1,
  parameter int POSW  = $clog2(2 * WIDTH)
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             enable,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic [LENW-1:0]  length,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] cct_output,
  output logic [POSW-1:0]  position,
  output logic             wrap,
  output logic             illegal
);

  rc_mode_t         r_mode;
  logic [5:0]       r_len;
  logic [WIDTH-1:0] r_cct;
  logic [POSW-1:0]  r_pos;
  logic             r_wrap;
  logic             r_illegal;

  rc_mode_t         w_modeEff;
  logic [5:0]       w_lenClamp;
  logic             w_cfgChange;
  logic [WIDTH-1:0] w_initNew;
  logic [WIDTH-1:0] w_initCur;
  logic             w_loadLegal;
  logic [POSW-1:0]  w_loadIndex;

  logic [WIDTH-1:0] w_mask;
  logic [WIDTH-1:0] w_hiOne;
  logic             w_topBit;
  logic             w_invert;
  logic [WIDTH-1:0] w_stepNext;
  logic [6:0]       w_period;
  logic [POSW-1:0]  w_lastPos;
  logic [POSW-1:0]  w_posNext;
  logic             w_wrapNext;

  assign w_modeEff   = rc_norm_mode(mode);
  assign w_lenClamp  = rc_clamp_len(6'(length), 6'(WIDTH));
  assign w_cfgChange = (w_modeEff != r_mode) || (w_lenClamp != r_len);
  assign w_initNew   = WIDTH'(rc_init_pattern(w_modeEff, w_lenClamp));
  assign w_initCur   = WIDTH'(rc_init_pattern(r_mode, r_len));

  ring_pattern_decode #(
    .WIDTH (WIDTH),
    .POSW  (POSW)
  ) u_decode (
    .i_pattern (load_value),
    .i_mode    (r_mode),
    .i_len     (r_len),
    .o_legal   (w_loadLegal),
    .o_index   (w_loadIndex)
  );

  // Next pattern for one step; rings recirculate the end bit, Johnson inverts it.
  always_comb begin
    w_mask     = WIDTH'(rc_len_mask(r_len));
    w_hiOne    = w_mask & ~(w_mask >> 1);
    w_topBit   = |(r_cct & w_hiOne);
    w_invert   = (r_mode == RC_JOHNSON);
    w_stepNext = r_cct;
    if (!dir)
      w_stepNext = ((r_cct << 1) & w_mask) | {{(WIDTH-1){1'b0}}, w_topBit ^ w_invert};
    else
      w_stepNext = (r_cct >> 1) | ((r_cct[0] ^ w_invert) ? w_hiOne : '0);
  end

  // Next position modulo the period, flagging the wrap crossing.
  always_comb begin
    w_period   = rc_period(r_mode, r_len);
    w_lastPos  = POSW'(w_period - 7'd1);
    w_posNext  = r_pos;
    w_wrapNext = 1'b0;
    if (!dir) begin
      if (r_pos == w_lastPos) begin
        w_posNext  = '0;
        w_wrapNext = 1'b1;
      end else begin
        w_posNext = r_pos + POSW'(1);
      end
    end else begin
      if (r_pos == '0) begin
        w_posNext  = w_lastPos;
        w_wrapNext = 1'b1;
      end else begin
        w_posNext = r_pos - POSW'(1);
      end
    end
  end

  // State update: config change beats load, load beats stepping.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      r_mode    <= RC_ONEHOT;
      r_len     <= 6'(WIDTH);
      r_cct     <= WIDTH'(1);
      r_pos     <= '0;
      r_wrap    <= 1'b0;
      r_illegal <= 1'b0;
    end else if (w_cfgChange) begin
      r_mode    <= w_modeEff;
      r_len     <= w_lenClamp;
      r_cct     <= w_initNew;
      r_pos     <= '0;
      r_wrap    <= 1'b0;
      r_illegal <= 1'b0;
    end else if (load) begin
      if (w_loadLegal) begin
        r_cct <= load_value;
        r_pos <= w_loadIndex;
      end else begin
        r_cct <= w_initCur;
        r_pos <= '0;
      end
      r_wrap    <= 1'b0;
      r_illegal <= !w_loadLegal;
    end else if (enable) begin
      r_cct     <= w_stepNext;
      r_pos     <= w_posNext;
      r_wrap    <= w_wrapNext;
      r_illegal <= 1'b0;
    end else begin
      r_wrap    <= 1'b0;
      r_illegal <= 1'b0;
    end
  end

  assign cct_output = r_cct;
  assign position   = r_pos;
  assign wrap       = r_wrap;
  assign illegal    = r_illegal;

endmodule

// File: tb/tb_ring_counter_multi.sv
// Directed bench for ring_counter_multi at WIDTH=8 with hand-computed vectors.
module tb_ring_counter_multi;

  logic       clk;
  logic       clear;
  logic       enable;
  logic       dir;
  logic [1:0] mode;
  logic [3:0] length;
  logic       load;
  logic [7:0] loadValue;
  logic [7:0] cctOutput;
  logic [3:0] position;
  logic       wrap;
  logic       illegal;

  int checks = 0;
  int errors = 0;

  ring_counter_multi #(.WIDTH(8)) dut (
    .clk        (clk),
    .clear      (clear),
    .enable     (enable),
    .dir        (dir),
    .mode       (mode),
    .length     (length),
    .load       (load),
    .load_value (loadValue),
    .cct_output (cctOutput),
    .position   (position),
    .wrap       (wrap),
    .illegal    (illegal)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive every control input at once.
  task automatic applyStimulus(input logic en, input logic d, input logic [1:0] m,
                               input logic [3:0] len, input logic ld, input logic [7:0] lv);
    enable    = en;
    dir       = d;
    mode      = m;
    length    = len;
    load      = ld;
    loadValue = lv;
  endtask

  // Advance one rising edge and settle just after it.
  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  // Compare all four outputs against the expected values.
  task automatic checkOutput(input string tag, input logic [7:0] expCct, input logic [3:0] expPos,
                             input logic expWrap, input logic expIll);
    checks++;
    assert (cctOutput === expCct) else begin
      errors++;
      $error("[TB] FAIL %s cct_output observed %h expected %h", tag, cctOutput, expCct);
    end
    checks++;
    assert (position === expPos) else begin
      errors++;
      $error("[TB] FAIL %s position observed %0d expected %0d", tag, position, expPos);
    end
    checks++;
    assert (wrap === expWrap) else begin
      errors++;
      $error("[TB] FAIL %s wrap observed %b expected %b", tag, wrap, expWrap);
    end
    checks++;
    assert (illegal === expIll) else begin
      errors++;
      $error("[TB] FAIL %s illegal observed %b expected %b", tag, illegal, expIll);
    end
  endtask

  // Directed sequence covering every mode, load checking, clamping and async clear.
  initial begin
    logic [7:0] johnUp [8];
    logic [7:0] coldDn [5];
    logic [3:0] coldPos [5];
    johnUp  = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h0E, 8'h0C, 8'h08, 8'h00};
    coldDn  = '{8'h0F, 8'h17, 8'h1B, 8'h1D, 8'h1E};
    coldPos = '{4'd4, 4'd3, 4'd2, 4'd1, 4'd0};

    clear = 1'b1;
    applyStimulus(1'b0, 1'b0, 2'b00, 4'd8, 1'b0, 8'h00);
    #12;
    checkOutput("reset", 8'h01, 4'd0, 1'b0, 1'b0);
    clear = 1'b0;

    // One-hot, L=8, up: full cycle with wrap on the return to 01.
    applyStimulus(1'b1, 1'b0, 2'b00, 4'd8, 1'b0, 8'h00);
    for (int k = 1; k <= 8; k++) begin
      stepClock();
      checkOutput("onehot_up", 8'h01 << (k % 8), 4'(k % 8), (k == 8), 1'b0);
    end

    // Johnson, L=4: mode change restarts at 00, then a full up cycle.
    applyStimulus(1'b1, 1'b0, 2'b01, 4'd4, 1'b0, 8'h00);
    stepClock();
    checkOutput("johnson_cfg", 8'h00, 4'd0, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      stepClock();
      checkOutput("johnson_up", johnUp[k], 4'((k + 1) % 8), (k == 7), 1'b0);
    end

    // Reverse direction: 00 -> 08 crosses 0 to P-1, then 0C.
    dir = 1'b1;
    stepClock();
    checkOutput("johnson_down_wrap", 8'h08, 4'd7, 1'b1, 1'b0);
    stepClock();
    checkOutput("johnson_down", 8'h0C, 4'd6, 1'b0, 1'b0);

    // Johnson loads: 07 is position 3; 05 is not a Johnson state.
    applyStimulus(1'b1, 1'b1, 2'b01, 4'd4, 1'b1, 8'h07);
    stepClock();
    checkOutput("johnson_load_ok", 8'h07, 4'd3, 1'b0, 1'b0);
    loadValue = 8'h05;
    stepClock();
    checkOutput("johnson_load_bad", 8'h00, 4'd0, 1'b0, 1'b1);

    // Reset pulse between edges, then one-cold L=5 counting down.
    load = 1'b0;
    #2 clear = 1'b1;
    #2 clear = 1'b0;
    applyStimulus(1'b1, 1'b1, 2'b10, 4'd5, 1'b0, 8'h00);
    stepClock();
    checkOutput("onecold_cfg", 8'h1E, 4'd0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      stepClock();
      checkOutput("onecold_down", coldDn[k], coldPos[k], (k == 0), 1'b0);
    end

    // One-hot, L=8, checked loads; illegal lasts exactly one cycle.
    applyStimulus(1'b0, 1'b0, 2'b00, 4'd8, 1'b0, 8'h00);
    stepClock();
    checkOutput("onehot_cfg", 8'h01, 4'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 2'b00, 4'd8, 1'b1, 8'h10);
    stepClock();
    checkOutput("load_legal", 8'h10, 4'd4, 1'b0, 1'b0);
    loadValue = 8'h11;
    stepClock();
    checkOutput("load_illegal", 8'h01, 4'd0, 1'b0, 1'b1);
    load = 1'b0;
    stepClock();
    checkOutput("illegal_clears", 8'h01, 4'd0, 1'b0, 1'b0);

    // Over-range length clamps to 8 and mode 11 acts as one-hot: no restart.
    applyStimulus(1'b1, 1'b0, 2'b00, 4'd15, 1'b0, 8'h00);
    stepClock();
    checkOutput("len_clamp_high", 8'h02, 4'd1, 1'b0, 1'b0);
    mode = 2'b11;
    stepClock();
    checkOutput("mode11_onehot", 8'h04, 4'd2, 1'b0, 1'b0);
    for (int k = 3; k <= 6; k++) begin
      stepClock();
      checkOutput("onehot_to_40", 8'h01 << k, 4'(k), 1'b0, 1'b0);
    end

    // Length change outranks load and enable in the same cycle.
    applyStimulus(1'b1, 1'b0, 2'b00, 4'd6, 1'b1, 8'h02);
    stepClock();
    checkOutput("len_change", 8'h01, 4'd0, 1'b0, 1'b0);
    load = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      stepClock();
      checkOutput("onehot_len6", 8'h01 << (k % 6), 4'(k % 6), (k == 6), 1'b0);
    end
    for (int k = 1; k <= 5; k++) begin
      stepClock();
    end
    checkOutput("at_20", 8'h20, 4'd5, 1'b0, 1'b0);

    // Asynchronous clear between edges, then resume from 01.
    #2 clear = 1'b1;
    #1;
    checkOutput("async_clear", 8'h01, 4'd0, 1'b0, 1'b0);
    length = 4'd8;
    #1 clear = 1'b0;
    stepClock();
    checkOutput("resume_1", 8'h02, 4'd1, 1'b0, 1'b0);
    stepClock();
    checkOutput("resume_2", 8'h04, 4'd2, 1'b0, 1'b0);

    // Length below 2 clamps to 2: restart, then toggle between 01 and 02.
    length = 4'd0;
    stepClock();
    checkOutput("len_clamp_low", 8'h01, 4'd0, 1'b0, 1'b0);
    stepClock();
    checkOutput("len2_step", 8'h02, 4'd1, 1'b0, 1'b0);
    stepClock();
    checkOutput("len2_wrap", 8'h01, 4'd0, 1'b1, 1'b0);

    // Enable low holds state and drops wrap.
    enable = 1'b0;
    stepClock();
    checkOutput("hold", 8'h01, 4'd0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
